// File: rtl/ctrl_pkt_arbiter.sv
// Round-robin packet arbiter merging four control-packet streams into one.
// Define CTRL_ARB_FIXED_PRIO_EN to give source 0 absolute priority in IDLE.
module ctrl_pkt_arbiter #(
  parameter int NUM_SRC   = 4,
  parameter int DATA_W    = 64,
  parameter int MAX_BEATS = 16
) (
  input  logic                        clk,
  input  logic                        core_rst_n,
  input  logic [NUM_SRC*DATA_W-1:0]   s_tdata,
  input  logic [NUM_SRC*DATA_W/8-1:0] s_tkeep,
  input  logic [NUM_SRC-1:0]          s_tvalid,
  input  logic [NUM_SRC-1:0]          s_tlast,
  output logic [NUM_SRC-1:0]          s_tready,
  output logic [DATA_W-1:0]           m_tdata,
  output logic [DATA_W/8-1:0]         m_tkeep,
  output logic                        m_tvalid,
  output logic                        m_tlast,
  input  logic                        m_tready,
  output logic [1:0]                  grant_id,
  output logic                        busy,
  output logic [31:0]                 pkt_count,
  output logic                        len_err
);

  localparam int KW = DATA_W / 8;
  localparam int BW = $clog2(MAX_BEATS + 1);

  typedef enum logic {IDLE, XFER} state_e;

  state_e        state_q, state_d;
  logic [1:0]    grant_q, grant_d;
  logic [1:0]    rr_q, rr_d;
  logic [BW-1:0] beat_q, beat_d;
  logic [31:0]   pkt_q, pkt_d;
  logic          len_err_q, len_err_d;

  logic [1:0]    win, idx;
  logic          win_vld;
  logic          acc, at_max, src_last;

  always_comb begin
    win     = rr_q;
    win_vld = 1'b0;
    idx     = rr_q;
`ifdef CTRL_ARB_FIXED_PRIO_EN
    if (s_tvalid[0]) begin
      win     = 2'd0;
      win_vld = 1'b1;
    end
`endif
    for (int i = 0; i < 4; i++) begin
      idx = rr_q + 2'(i);
`ifdef CTRL_ARB_FIXED_PRIO_EN
      if (!win_vld && idx != 2'd0 && s_tvalid[idx]) begin
`else
      if (!win_vld && s_tvalid[idx]) begin
`endif
        win     = idx;
        win_vld = 1'b1;
      end
    end
  end

  // Beat MAX_BEATS-1 (zero based) is the last one a packet may carry
  assign at_max   = (beat_q == BW'(MAX_BEATS - 1));
  assign src_last = s_tlast[grant_q];

  always_comb begin
    m_tdata  = '0;
    m_tkeep  = '0;
    m_tvalid = 1'b0;
    m_tlast  = 1'b0;
    s_tready = '0;
    if (state_q == XFER) begin
      m_tdata  = s_tdata[int'(grant_q)*DATA_W +: DATA_W];
      m_tkeep  = s_tkeep[int'(grant_q)*KW +: KW];
      m_tvalid = s_tvalid[grant_q];
      m_tlast  = src_last | at_max;
      s_tready[grant_q] = m_tready;
    end
  end

  assign acc = m_tvalid & m_tready;

  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    rr_d      = rr_q;
    beat_d    = beat_q;
    pkt_d     = pkt_q;
    len_err_d = len_err_q;
    unique case (state_q)
      IDLE: begin
        if (win_vld) begin
          grant_d = win;
          state_d = XFER;
        end
      end
      XFER: begin
        if (acc) begin
          if (src_last || at_max) begin
            state_d = IDLE;
            rr_d    = grant_q + 2'd1;
            pkt_d   = pkt_q + 32'd1;
            beat_d  = '0;
            if (!src_last) len_err_d = 1'b1;
          end else begin
            beat_d = beat_q + 1'b1;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge core_rst_n) begin
    if (!core_rst_n) begin
      state_q   <= IDLE;
      grant_q   <= '0;
      rr_q      <= '0;
      beat_q    <= '0;
      pkt_q     <= '0;
      len_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      rr_q      <= rr_d;
      beat_q    <= beat_d;
      pkt_q     <= pkt_d;
      len_err_q <= len_err_d;
    end
  end

  assign grant_id  = grant_q;
  assign busy      = (state_q == XFER);
  assign pkt_count = pkt_q;
  assign len_err   = len_err_q;

endmodule

// File: tb/tb_ctrl_pkt_arbiter.sv
// Bench for ctrl_pkt_arbiter: grant table, directed corner sequences and
// randomized traffic against a packet-level reference model.
module tb_ctrl_pkt_arbiter;
  localparam int MAXB = 16;

  logic         clk = 1'b0;
  logic         core_rst_n;
  logic [255:0] s_tdata;
  logic [31:0]  s_tkeep;
  logic [3:0]   s_tvalid, s_tlast, s_tready;
  logic [63:0]  m_tdata;
  logic [7:0]   m_tkeep;
  logic         m_tvalid, m_tlast, m_tready;
  logic [1:0]   grant_id;
  logic         busy, len_err;
  logic [31:0]  pkt_count;

  always #5 clk = ~clk;

  ctrl_pkt_arbiter #(.NUM_SRC(4), .DATA_W(64), .MAX_BEATS(MAXB)) dut (
    .clk(clk), .core_rst_n(core_rst_n),
    .s_tdata(s_tdata), .s_tkeep(s_tkeep), .s_tvalid(s_tvalid),
    .s_tlast(s_tlast), .s_tready(s_tready),
    .m_tdata(m_tdata), .m_tkeep(m_tkeep), .m_tvalid(m_tvalid),
    .m_tlast(m_tlast), .m_tready(m_tready),
    .grant_id(grant_id), .busy(busy), .pkt_count(pkt_count),
    .len_err(len_err)
  );

  typedef struct {logic [63:0] d; logic [7:0] k; logic l;} beat_t;
  typedef struct {logic [1:0] g; logic [63:0] d; logic l;} obeat_t;
  typedef struct {logic [3:0] req; logic [1:0] grr; logic [1:0] gfp;} vec_t;

  beat_t  sq[4][$];
  obeat_t olog[$];
  logic [3:0] en;
  int rdy_mode;
  logic tog;
  int total, bad;

  // reference model state
  logic       mb;
  logic [1:0] mown;
  int         mrr, mbeats;
  logic [31:0] mpkt;
  logic       mlerr;

  task automatic chk(input string nm, input logic [63:0] a,
                     input logic [63:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s act=%h exp=%h t=%0t", nm, a, e, $time);
    end
  endtask

  task automatic drive();
    s_tdata = '0; s_tkeep = '0; s_tvalid = '0; s_tlast = '0;
    for (int i = 0; i < 4; i++) begin
      if (sq[i].size() > 0 && en[i]) begin
        s_tvalid[i] = 1'b1;
        s_tdata[i*64 +: 64] = sq[i][0].d;
        s_tkeep[i*8 +: 8] = sq[i][0].k;
        s_tlast[i] = sq[i][0].l;
      end
    end
    tog = ~tog;
    case (rdy_mode)
      0: m_tready = 1'b1;
      1: m_tready = tog;
      default: m_tready = ($urandom_range(0, 3) != 0);
    endcase
  endtask

  function automatic logic [1:0] pick(input logic [3:0] v);
    logic [1:0] r = 2'd0;
    logic f = 1'b0;
`ifdef CTRL_ARB_FIXED_PRIO_EN
    if (v[0]) return 2'd0;
    for (int k = 0; k < 4; k++)
      if (!f && ((mrr + k) % 4) != 0 && v[(mrr + k) % 4]) begin
        r = 2'((mrr + k) % 4); f = 1'b1;
      end
`else
    for (int k = 0; k < 4; k++)
      if (!f && v[(mrr + k) % 4]) begin
        r = 2'((mrr + k) % 4); f = 1'b1;
      end
`endif
    return r;
  endfunction

  task automatic model_check();
    logic [3:0] er = '0;
    logic [63:0] ed = '0;
    logic [7:0] ek = '0;
    logic ev = 1'b0, el = 1'b0;
    int g = int'(mown);
    if (mb) begin
      ev = s_tvalid[g];
      ed = s_tdata[g*64 +: 64];
      ek = s_tkeep[g*8 +: 8];
      el = s_tlast[g] | (mbeats == MAXB - 1);
      er[g] = m_tready;
    end
    chk("busy", 64'(busy), 64'(mb));
    chk("grant_id", 64'(grant_id), 64'(mown));
    chk("m_tvalid", 64'(m_tvalid), 64'(ev));
    chk("m_tdata", m_tdata, ed);
    chk("m_tkeep", 64'(m_tkeep), 64'(ek));
    chk("m_tlast", 64'(m_tlast), 64'(el));
    chk("s_tready", 64'(s_tready), 64'(er));
    chk("pkt_count", 64'(pkt_count), 64'(mpkt));
    chk("len_err", 64'(len_err), 64'(mlerr));
  endtask

  task automatic model_step();
    logic lst;
    if (!mb) begin
      if (|s_tvalid) begin
        mown = pick(s_tvalid);
        mb = 1'b1;
      end
    end else if (s_tvalid[mown] && m_tready) begin
      lst = s_tlast[mown];
      mbeats++;
      if (lst || mbeats == MAXB) begin
        mb = 1'b0;
        mrr = (int'(mown) + 1) % 4;
        mpkt++;
        if (!lst) mlerr = 1'b1;
        mbeats = 0;
      end
    end
  endtask

  task automatic tick();
    logic [3:0] pop;
    @(negedge clk);
    model_check();
    if (m_tvalid && m_tready) olog.push_back('{grant_id, m_tdata, m_tlast});
    pop = s_tvalid & s_tready;
    model_step();
    @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++)
      if (pop[i]) void'(sq[i].pop_front());
    drive();
  endtask

  task automatic clear_all();
    mb = 1'b0; mown = 2'd0; mrr = 0; mbeats = 0; mpkt = '0; mlerr = 1'b0;
    for (int i = 0; i < 4; i++) sq[i].delete();
    olog.delete();
    en = 4'hF;
    rdy_mode = 0;
  endtask

  task automatic do_reset();
    core_rst_n = 1'b0;
    clear_all();
    drive();
    #2;
    @(posedge clk);
    #1;
    core_rst_n = 1'b1;
  endtask

  task automatic push_pkt(input int s, input int n, input logic [63:0] base,
                          input logic lastf);
    for (int b = 0; b < n; b++)
      sq[s].push_back('{base + 64'(b), 8'hFF, lastf && (b == n - 1)});
  endtask

  task automatic run_until(input int n, input int budget);
    int c = 0;
    while (pkt_count != 32'(n) && c < budget) begin
      tick();
      c++;
    end
    chk("wait_pkts", 64'(pkt_count), 64'(n));
  endtask

  vec_t tv[8];
  logic [1:0] ord[8];
  logic [1:0] eg;
  int c;

  initial begin
    total = 0; bad = 0; tog = 1'b0;
    core_rst_n = 1'b0;
    m_tready = 1'b0;
    en = 4'hF;
    rdy_mode = 0;

    tv[0] = '{4'b1111, 2'd0, 2'd0};
    tv[1] = '{4'b1111, 2'd1, 2'd0};
    tv[2] = '{4'b0001, 2'd0, 2'd0};
    tv[3] = '{4'b1100, 2'd2, 2'd2};
    tv[4] = '{4'b0110, 2'd1, 2'd1};
    tv[5] = '{4'b1000, 2'd3, 2'd3};
    tv[6] = '{4'b1010, 2'd1, 2'd1};
    tv[7] = '{4'b0011, 2'd0, 2'd0};
`ifdef CTRL_ARB_FIXED_PRIO_EN
    ord = '{2'd0, 2'd0, 2'd1, 2'd2, 2'd3, 2'd1, 2'd2, 2'd3};
`else
    ord = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1, 2'd2, 2'd3};
`endif

    // reset values
    do_reset();
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_grant", 64'(grant_id), 64'd0);
    chk("rst_pkts", 64'(pkt_count), 64'd0);
    chk("rst_lerr", 64'(len_err), 64'd0);
    chk("rst_mvalid", 64'(m_tvalid), 64'd0);

    // single 8-beat handshake from source 0
    push_pkt(0, 8, 64'h8000_0000_0000_0000, 1'b1);
    drive();
    tick();
    chk("lat_first", 64'(m_tvalid), 64'd1);
    run_until(1, 40);
    chk("hs_beats", 64'(olog.size()), 64'd8);
    for (int b = 0; b < 8 && b < olog.size(); b++) begin
      chk("hs_data", olog[b].d, 64'h8000_0000_0000_0000 + 64'(b));
      chk("hs_last", 64'(olog[b].l), 64'(b == 7));
      chk("hs_grant", 64'(olog[b].g), 64'd0);
    end

    // grant table
    do_reset();
    for (int v = 0; v < 8; v++) begin
`ifdef CTRL_ARB_FIXED_PRIO_EN
      eg = tv[v].gfp;
`else
      eg = tv[v].grr;
`endif
      for (int i = 0; i < 4; i++)
        if (tv[v].req[i]) push_pkt(i, 1, 64'(v * 16 + i), 1'b1);
      drive();
      tick();
      chk("tbl_busy", 64'(busy), 64'd1);
      chk("tbl_grant", 64'(grant_id), 64'(eg));
      chk("tbl_data", m_tdata, 64'(v * 16 + int'(eg)));
      tick();
      for (int i = 0; i < 4; i++) sq[i].delete();
      drive();
      chk("tbl_pkts", 64'(pkt_count), 64'(v + 1));
    end

    // all four sources, two 2-beat packets each
    do_reset();
    for (int i = 0; i < 4; i++) begin
      push_pkt(i, 2, 64'(i * 256), 1'b1);
      push_pkt(i, 2, 64'(i * 256 + 16), 1'b1);
    end
    drive();
    run_until(8, 100);
    chk("rr_beats", 64'(olog.size()), 64'd16);
    for (int p = 0; p < 8 && 2 * p + 1 < olog.size(); p++) begin
      chk("rr_order", 64'(olog[2*p].g), 64'(ord[p]));
      chk("rr_lock", 64'(olog[2*p+1].g), 64'(ord[p]));
      chk("rr_last", 64'(olog[2*p+1].l), 64'd1);
    end

    // source 0 requests while source 2 is mid-packet
    do_reset();
    push_pkt(2, 4, 64'h2000, 1'b1);
    drive();
    tick(); tick(); tick();
    push_pkt(0, 2, 64'h0100, 1'b1);
    drive();
    run_until(2, 40);
    chk("mid_beats", 64'(olog.size()), 64'd6);
    for (int b = 0; b < 6 && b < olog.size(); b++)
      chk("mid_grant", 64'(olog[b].g), (b < 4) ? 64'd2 : 64'd0);

    // m_tready toggling during an 8-beat packet
    do_reset();
    rdy_mode = 1;
    push_pkt(1, 8, 64'h1111_0000, 1'b1);
    drive();
    run_until(1, 60);
    chk("tog_beats", 64'(olog.size()), 64'd8);
    for (int b = 0; b < 8 && b < olog.size(); b++)
      chk("tog_data", olog[b].d, 64'h1111_0000 + 64'(b));

    // 20 beats without tlast from source 1
    do_reset();
    push_pkt(1, 20, 64'h5500, 1'b0);
    push_pkt(3, 1, 64'h3300, 1'b1);
    drive();
    c = 0;
    while (olog.size() < 16 && c < 60) begin tick(); c++; end
    chk("len_cnt", 64'(olog.size()), 64'd16);
    chk("len_err", 64'(len_err), 64'd1);
    chk("len_idle", 64'(busy), 64'd0);
    if (olog.size() >= 16) chk("len_flast", 64'(olog[15].l), 64'd1);
    run_until(2, 20);
    if (olog.size() >= 17) chk("len_next", 64'(olog[16].g), 64'd3);
    else chk("len_next_seen", 64'(olog.size()), 64'd17);

    // reset pulsed at beat 3 of a packet
    do_reset();
    push_pkt(1, 1, 64'h77, 1'b1);
    drive();
    run_until(1, 20);
    push_pkt(2, 6, 64'h6600, 1'b1);
    drive();
    c = 0;
    while (olog.size() < 3 && c < 40) begin tick(); c++; end
    chk("rm_pre_busy", 64'(busy), 64'd1);
    core_rst_n = 1'b0;
    #1;
    chk("rm_busy", 64'(busy), 64'd0);
    chk("rm_grant", 64'(grant_id), 64'd0);
    chk("rm_mvalid", 64'(m_tvalid), 64'd0);
    chk("rm_mlast", 64'(m_tlast), 64'd0);
    chk("rm_mdata", m_tdata, 64'd0);
    chk("rm_mkeep", 64'(m_tkeep), 64'd0);
    chk("rm_sready", 64'(s_tready), 64'd0);
    chk("rm_pkts", 64'(pkt_count), 64'd0);
    chk("rm_lerr", 64'(len_err), 64'd0);
    clear_all();
    drive();
    @(posedge clk);
    #1;
    core_rst_n = 1'b1;
    for (int i = 0; i < 4; i++) push_pkt(i, 1, 64'(32'hA0 + i), 1'b1);
    drive();
    run_until(1, 20);
    if (olog.size() >= 1) begin
      chk("rm_after_grant", 64'(olog[0].g), 64'd0);
      chk("rm_after_data", olog[0].d, 64'hA0);
    end else chk("rm_after_seen", 64'(olog.size()), 64'd1);

    // randomized traffic
    do_reset();
    rdy_mode = 2;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      en = 4'($urandom);
      for (int i = 0; i < 4; i++)
        if (sq[i].size() < 4 && $urandom_range(0, 7) == 0) begin
          if ($urandom_range(0, 15) == 0)
            push_pkt(i, 20, {$urandom, $urandom}, 1'b0);
          else
            push_pkt(i, $urandom_range(1, 6), {$urandom, $urandom}, 1'b1);
        end
      tick();
    end
    chk("rnd_pkts", 64'(pkt_count), 64'(mpkt));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
